dispatch: RTL and testbench

//  Stage directly downstream of regfile: latches the renamed-operand packet, allocates a ROB tag and renames rd.

---
 rtl/dispatch.sv | 165 ++++++++++++++++
 tb/tb_dispatch.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch.sv
// dispatch: single-entry holding stage between regfile and RS/LSB; allocates ROB tag, renames rd, resolves operands.
// Optional DP_CDB_BYPASS_EN: wake held/captured operands straight off the CDB instead of waiting for the ROB lookup.
module dispatch (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        iREG_en,
  input  logic [4:0]  iREG_rs1_regnm,
  input  logic [4:0]  iREG_rs2_regnm,
  input  logic [3:0]  iREG_rs1_nick,
  input  logic [3:0]  iREG_rs2_nick,
  input  logic [31:0] iREG_rs1_dt,
  input  logic [31:0] iREG_rs2_dt,
  input  logic [5:0]  iREG_op,
  input  logic [31:0] iREG_pc,
  input  logic [31:0] iREG_imm,
  input  logic        iREG_pd,
  input  logic [4:0]  iREG_rd_regnm,
  output logic        oIND_stall,
  input  logic        iROB_full,
  input  logic [3:0]  iROB_free_nick,
  output logic        oROB_en,
  output logic        oREG_nick_en,
  output logic [3:0]  oROB_q1_nick,
  output logic [3:0]  oROB_q2_nick,
  input  logic        iROB_q1_rdy,
  input  logic [31:0] iROB_q1_dt,
  input  logic        iROB_q2_rdy,
  input  logic [31:0] iROB_q2_dt,
  input  logic        iCDB_en,
  input  logic [3:0]  iCDB_nick,
  input  logic [31:0] iCDB_dt,
  input  logic        iRS_full,
  input  logic        iLSB_full,
  output logic        oRS_en,
  output logic        oLSB_en,
  output logic [5:0]  oIS_op,
  output logic [31:0] oIS_pc,
  output logic [31:0] oIS_imm,
  output logic        oIS_pd,
  output logic [4:0]  oIS_rd_regnm,
  output logic [3:0]  oIS_nick,
  output logic [3:0]  oIS_q1,
  output logic [3:0]  oIS_q2,
  output logic [31:0] oIS_v1,
  output logic [31:0] oIS_v2
);
  localparam logic [5:0] OP_BEQ = 6'd5, OP_BGEU = 6'd10, OP_LB = 6'd11, OP_SB = 6'd16, OP_SW = 6'd18;
`ifdef DP_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_n;
  logic [5:0] h_op;
  logic [31:0] h_pc, h_imm;
  logic h_pd;
  logic [4:0] h_rd;
  logic [1:0][3:0] h_q, u_q, c_q, r_nick;
  logic [1:0][31:0] h_v, u_v, c_v, r_dt, l_dt;
  logic [1:0][4:0] r_nm;
  logic [1:0] l_rdy, wake, cbh, cbc, haz;
  logic hold, h_ls, h_ren, blocked, issue, capture;

  assign r_nm = {iREG_rs2_regnm, iREG_rs1_regnm};
  assign r_nick = {iREG_rs2_nick, iREG_rs1_nick};
  assign r_dt = {iREG_rs2_dt, iREG_rs1_dt};
  assign l_rdy = {iROB_q2_rdy, iROB_q1_rdy};
  assign l_dt = {iROB_q2_dt, iROB_q1_dt};
  assign hold = state == HOLD;
  assign h_ls = h_op >= OP_LB && h_op <= OP_SW;
  assign h_ren = |h_rd && !(h_op >= OP_SB && h_op <= OP_SW) && !(h_op >= OP_BEQ && h_op <= OP_BGEU);
  assign blocked = hold && (iROB_full || (h_ls ? iLSB_full : iRS_full));
  assign issue = rdy && !clr && hold && !blocked;
  assign capture = rdy && !clr && iREG_en && !blocked;
  assign oIND_stall = blocked;
  assign oROB_q1_nick = hold ? h_q[0] : '0;
  assign oROB_q2_nick = hold ? h_q[1] : '0;

  // u_*: held operands after this cycle's wakeup; c_*: operands of the packet being captured
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cbh[i] = BYP && iCDB_en && |h_q[i] && iCDB_nick == h_q[i];
      wake[i] = |h_q[i] && (l_rdy[i] || cbh[i]);
      u_q[i] = wake[i] ? '0 : h_q[i];
      u_v[i] = !wake[i] ? h_v[i] : l_rdy[i] ? l_dt[i] : iCDB_dt;
      haz[i] = issue && h_ren && r_nm[i] == h_rd;
      cbc[i] = BYP && iCDB_en && |r_nick[i] && iCDB_nick == r_nick[i];
      c_q[i] = haz[i] ? iROB_free_nick : (~|r_nm[i] || cbc[i]) ? '0 : r_nick[i];
      c_v[i] = (~|r_nm[i] || haz[i]) ? '0 : cbc[i] ? iCDB_dt : r_dt[i];
    end
  end

  always_comb state_n = (rdy && clr) ? IDLE : capture ? HOLD : issue ? IDLE : state;

  always_ff @(posedge clk) state <= rst ? IDLE : state_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_op <= '0;
      h_pc <= '0;
      h_imm <= '0;
      h_pd <= 1'b0;
      h_rd <= '0;
      h_q <= '0;
      h_v <= '0;
      oROB_en <= 1'b0;
      oREG_nick_en <= 1'b0;
      oRS_en <= 1'b0;
      oLSB_en <= 1'b0;
      oIS_op <= '0;
      oIS_pc <= '0;
      oIS_imm <= '0;
      oIS_pd <= 1'b0;
      oIS_rd_regnm <= '0;
      oIS_nick <= '0;
      oIS_q1 <= '0;
      oIS_q2 <= '0;
      oIS_v1 <= '0;
      oIS_v2 <= '0;
    end else begin
      oROB_en <= issue;
      oRS_en <= issue && !h_ls;
      oLSB_en <= issue && h_ls;
      oREG_nick_en <= issue && h_ren;
      if (rdy && clr) begin
        oIS_op <= '0;
        oIS_pc <= '0;
        oIS_imm <= '0;
        oIS_pd <= 1'b0;
        oIS_rd_regnm <= '0;
        oIS_nick <= '0;
        oIS_q1 <= '0;
        oIS_q2 <= '0;
        oIS_v1 <= '0;
        oIS_v2 <= '0;
      end else if (issue) begin
        oIS_op <= h_op;
        oIS_pc <= h_pc;
        oIS_imm <= h_imm;
        oIS_pd <= h_pd;
        oIS_rd_regnm <= h_rd;
        oIS_nick <= iROB_free_nick;
        oIS_q1 <= u_q[0];
        oIS_q2 <= u_q[1];
        oIS_v1 <= u_v[0];
        oIS_v2 <= u_v[1];
      end
      if (capture) begin
        h_op <= iREG_op;
        h_pc <= iREG_pc;
        h_imm <= iREG_imm;
        h_pd <= iREG_pd;
        h_rd <= iREG_rd_regnm;
        h_q <= c_q;
        h_v <= c_v;
      end else if (rdy && hold) begin
        h_q <= u_q;
        h_v <= u_v;
      end
    end
  end
endmodule

// File: tb/tb_dispatch.sv
// tb_dispatch: scenario tasks drive packets and push expected issues; a negedge monitor pops and compares them.
module tb_dispatch;
  localparam logic [5:0] OP_BEQ = 6'd5, OP_LW = 6'd13, OP_SW = 6'd18, OP_ADD = 6'd28;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rdy, clr, iREG_en, iREG_pd, iROB_full, iROB_q1_rdy, iROB_q2_rdy, iCDB_en, iRS_full, iLSB_full;
  logic [4:0] iREG_rs1_regnm, iREG_rs2_regnm, iREG_rd_regnm;
  logic [3:0] iREG_rs1_nick, iREG_rs2_nick, iROB_free_nick, iCDB_nick;
  logic [31:0] iREG_rs1_dt, iREG_rs2_dt, iREG_pc, iREG_imm, iROB_q1_dt, iROB_q2_dt, iCDB_dt;
  logic [5:0] iREG_op;
  logic oIND_stall, oROB_en, oREG_nick_en, oRS_en, oLSB_en, oIS_pd;
  logic [3:0] oROB_q1_nick, oROB_q2_nick, oIS_nick, oIS_q1, oIS_q2;
  logic [5:0] oIS_op;
  logic [31:0] oIS_pc, oIS_imm, oIS_v1, oIS_v2;
  logic [4:0] oIS_rd_regnm;

  dispatch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .iREG_en(iREG_en),
    .iREG_rs1_regnm(iREG_rs1_regnm), .iREG_rs2_regnm(iREG_rs2_regnm),
    .iREG_rs1_nick(iREG_rs1_nick), .iREG_rs2_nick(iREG_rs2_nick),
    .iREG_rs1_dt(iREG_rs1_dt), .iREG_rs2_dt(iREG_rs2_dt),
    .iREG_op(iREG_op), .iREG_pc(iREG_pc), .iREG_imm(iREG_imm), .iREG_pd(iREG_pd),
    .iREG_rd_regnm(iREG_rd_regnm), .oIND_stall(oIND_stall),
    .iROB_full(iROB_full), .iROB_free_nick(iROB_free_nick), .oROB_en(oROB_en),
    .oREG_nick_en(oREG_nick_en), .oROB_q1_nick(oROB_q1_nick), .oROB_q2_nick(oROB_q2_nick),
    .iROB_q1_rdy(iROB_q1_rdy), .iROB_q1_dt(iROB_q1_dt), .iROB_q2_rdy(iROB_q2_rdy), .iROB_q2_dt(iROB_q2_dt),
    .iCDB_en(iCDB_en), .iCDB_nick(iCDB_nick), .iCDB_dt(iCDB_dt),
    .iRS_full(iRS_full), .iLSB_full(iLSB_full), .oRS_en(oRS_en), .oLSB_en(oLSB_en),
    .oIS_op(oIS_op), .oIS_pc(oIS_pc), .oIS_imm(oIS_imm), .oIS_pd(oIS_pd),
    .oIS_rd_regnm(oIS_rd_regnm), .oIS_nick(oIS_nick), .oIS_q1(oIS_q1), .oIS_q2(oIS_q2),
    .oIS_v1(oIS_v1), .oIS_v2(oIS_v2)
  );

  typedef struct {
    logic [5:0] op; logic [31:0] pc, imm, v1, v2; logic pd; logic [4:0] rd;
    logic [3:0] nick, q1, q2; logic lsb, ren;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (oROB_en || oRS_en || oLSB_en)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue got op=%0d nick=%0d want no issue", oIS_op, oIS_nick);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({oROB_en, oRS_en, oLSB_en} !== {1'b1, ~e.lsb, e.lsb}) begin
          errors++; $display("FAIL issue_pulses got rob/rs/lsb=%b want %b", {oROB_en, oRS_en, oLSB_en}, {1'b1, ~e.lsb, e.lsb});
        end
        checks++;
        if (oREG_nick_en !== e.ren) begin
          errors++; $display("FAIL issue_rename got=%b want=%b", oREG_nick_en, e.ren);
        end
        checks++;
        if ({oIS_op, oIS_pc, oIS_imm, oIS_pd, oIS_rd_regnm} !== {e.op, e.pc, e.imm, e.pd, e.rd}) begin
          errors++; $display("FAIL issue_fields got op=%0d pc=%h imm=%h pd=%b rd=%0d want op=%0d pc=%h imm=%h pd=%b rd=%0d",
                             oIS_op, oIS_pc, oIS_imm, oIS_pd, oIS_rd_regnm, e.op, e.pc, e.imm, e.pd, e.rd);
        end
        checks++;
        if ({oIS_nick, oIS_q1, oIS_q2} !== {e.nick, e.q1, e.q2}) begin
          errors++; $display("FAIL issue_tags got nick=%0d q1=%0d q2=%0d want nick=%0d q1=%0d q2=%0d",
                             oIS_nick, oIS_q1, oIS_q2, e.nick, e.q1, e.q2);
        end
        checks++;
        if ((e.q1 == 0 && oIS_v1 !== e.v1) || (e.q2 == 0 && oIS_v2 !== e.v2)) begin
          errors++; $display("FAIL issue_values got v1=%h v2=%h want v1=%h v2=%h", oIS_v1, oIS_v2, e.v1, e.v2);
        end
      end
    end
  end

  task automatic cyc; @(posedge clk); #1; endtask
  task automatic neg; @(negedge clk); endtask

  task automatic offer(input logic [5:0] op, input logic [4:0] rd, rs1, rs2, input logic [3:0] n1, n2,
                       input logic [31:0] d1, d2, imm, pc, input logic pd);
    iREG_en = 1'b1; iREG_op = op; iREG_rd_regnm = rd; iREG_rs1_regnm = rs1; iREG_rs2_regnm = rs2;
    iREG_rs1_nick = n1; iREG_rs2_nick = n2; iREG_rs1_dt = d1; iREG_rs2_dt = d2;
    iREG_imm = imm; iREG_pc = pc; iREG_pd = pd;
  endtask

  task automatic expect_is(input logic [5:0] op, input logic [31:0] pc, imm, input logic pd, input logic [4:0] rd,
                           input logic [3:0] nick, q1, input logic [31:0] v1, input logic [3:0] q2,
                           input logic [31:0] v2, input logic lsb, ren);
    exp_t e;
    e.op = op; e.pc = pc; e.imm = imm; e.pd = pd; e.rd = rd; e.nick = nick;
    e.q1 = q1; e.v1 = v1; e.q2 = q2; e.v2 = v2; e.lsb = lsb; e.ren = ren;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; iREG_en = 1'b0; iREG_pd = 1'b0; iROB_full = 1'b0;
    iROB_q1_rdy = 1'b0; iROB_q2_rdy = 1'b0; iCDB_en = 1'b0; iRS_full = 1'b0; iLSB_full = 1'b0;
    iREG_rs1_regnm = '0; iREG_rs2_regnm = '0; iREG_rd_regnm = '0; iREG_rs1_nick = '0; iREG_rs2_nick = '0;
    iROB_free_nick = '0; iCDB_nick = '0; iREG_rs1_dt = '0; iREG_rs2_dt = '0; iREG_pc = '0; iREG_imm = '0;
    iROB_q1_dt = '0; iROB_q2_dt = '0; iCDB_dt = '0; iREG_op = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    neg;
    checks++;
    if ({oIND_stall, oROB_en, oRS_en, oLSB_en, oREG_nick_en} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=00000", {oIND_stall, oROB_en, oRS_en, oLSB_en, oREG_nick_en});
    end
    checks++;
    if ({oIS_nick, oIS_q1, oIS_q2, oROB_q1_nick, oROB_q2_nick, oIS_op, oIS_pd, oIS_rd_regnm} !== '0) begin
      errors++; $display("FAIL reset_tags got nick=%0d q1=%0d q2=%0d op=%0d", oIS_nick, oIS_q1, oIS_q2, oIS_op);
    end
    checks++;
    if ({oIS_pc, oIS_imm, oIS_v1, oIS_v2} !== '0) begin
      errors++; $display("FAIL reset_data got pc=%h imm=%h v1=%h v2=%h want 0", oIS_pc, oIS_imm, oIS_v1, oIS_v2);
    end
    iROB_free_nick = 4'd1;
    offer(OP_ADD, 5'd1, 5'd2, 5'd3, 4'd0, 4'd0, 32'h11, 32'h22, 32'h0, 32'h100, 1'b0);
    expect_is(OP_ADD, 32'h100, 32'h0, 1'b0, 5'd1, 4'd1, 4'd0, 32'h11, 4'd0, 32'h22, 1'b0, 1'b1);
    cyc; iREG_en = 1'b0; neg;
    checks++;
    if (oRS_en !== 1'b0) begin errors++; $display("FAIL reset_add_early got rs_en=%b want=0", oRS_en); end
    cyc; neg;
    checks++;
    if ({oRS_en, oROB_en, oREG_nick_en} !== 3'b111) begin
      errors++; $display("FAIL reset_add_issue got rs/rob/ren=%b want=111", {oRS_en, oROB_en, oREG_nick_en});
    end
    cyc; neg;
    checks++;
    if ({oRS_en, oROB_en} !== 2'b00 || sb.size() != 0) begin
      errors++; $display("FAIL reset_add_done got rs/rob=%b pending=%0d want 00 and 0", {oRS_en, oROB_en}, sb.size());
    end
  endtask

  task automatic test_back_to_back;
    iROB_free_nick = 4'd3;
    offer(OP_LW, 5'd5, 5'd1, 5'd0, 4'd0, 4'd0, 32'd100, 32'd0, 32'd8, 32'h200, 1'b0);
    expect_is(OP_LW, 32'h200, 32'd8, 1'b0, 5'd5, 4'd3, 4'd0, 32'd100, 4'd0, 32'd0, 1'b1, 1'b1);
    cyc;
    offer(OP_ADD, 5'd6, 5'd5, 5'd5, 4'd0, 4'd0, 32'h55, 32'h55, 32'd0, 32'h204, 1'b0);
    expect_is(OP_ADD, 32'h204, 32'd0, 1'b0, 5'd6, 4'd4, 4'd3, 32'd0, 4'd3, 32'd0, 1'b0, 1'b1);
    neg;
    checks++;
    if (oIND_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got=%b want=0", oIND_stall); end
    cyc; iREG_en = 1'b0; iROB_free_nick = 4'd4; neg;
    checks++;
    if ({oLSB_en, oIS_nick, oROB_q1_nick, oROB_q2_nick} !== {1'b1, 4'd3, 4'd3, 4'd3}) begin
      errors++; $display("FAIL b2b_lw got lsb=%b nick=%0d lookup=%0d/%0d want 1 3 3/3", oLSB_en, oIS_nick, oROB_q1_nick, oROB_q2_nick);
    end
    cyc; neg;
    checks++;
    if ({oRS_en, oIS_q1, oIS_nick} !== {1'b1, 4'd3, 4'd4}) begin
      errors++; $display("FAIL b2b_add got rs=%b q1=%0d nick=%0d want 1 3 4", oRS_en, oIS_q1, oIS_nick);
    end
    cyc; neg;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending got=%0d want=0", sb.size()); end
  endtask

  task automatic test_stall;
    iROB_free_nick = 4'd5;
    offer(OP_ADD, 5'd7, 5'd1, 5'd2, 4'd0, 4'd0, 32'd1, 32'd2, 32'd0, 32'h300, 1'b0);
    expect_is(OP_ADD, 32'h300, 32'd0, 1'b0, 5'd7, 4'd5, 4'd0, 32'd1, 4'd0, 32'd2, 1'b0, 1'b1);
    cyc;
    iRS_full = 1'b1;
    offer(OP_SW, 5'd0, 5'd3, 5'd4, 4'd0, 4'd0, 32'h30, 32'h40, 32'd4, 32'h304, 1'b0);
    expect_is(OP_SW, 32'h304, 32'd4, 1'b0, 5'd0, 4'd6, 4'd0, 32'h30, 4'd0, 32'h40, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      neg;
      checks++;
      if ({oIND_stall, oRS_en, oROB_en} !== 3'b100) begin
        errors++; $display("FAIL stall_cycle%0d got stall/rs/rob=%b want=100", i, {oIND_stall, oRS_en, oROB_en});
      end
      if (i < 2) cyc;
    end
    iRS_full = 1'b0;
    cyc; iREG_en = 1'b0; iROB_free_nick = 4'd6; neg;
    checks++;
    if ({oRS_en, oIND_stall} !== 2'b10) begin
      errors++; $display("FAIL stall_release got rs/stall=%b want=10", {oRS_en, oIND_stall});
    end
    cyc; neg;
    checks++;
    if ({oRS_en, oLSB_en, oREG_nick_en} !== 3'b010) begin
      errors++; $display("FAIL stall_next_sw got rs/lsb/ren=%b want=010", {oRS_en, oLSB_en, oREG_nick_en});
    end
    cyc; neg;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stall_pending got=%0d want=0", sb.size()); end
  endtask

  task automatic test_sw_x0;
    iROB_free_nick = 4'd7;
    offer(OP_SW, 5'd0, 5'd0, 5'd2, 4'd7, 4'd0, 32'hbad, 32'h22, 32'd12, 32'h400, 1'b0);
    expect_is(OP_SW, 32'h400, 32'd12, 1'b0, 5'd0, 4'd7, 4'd0, 32'd0, 4'd0, 32'h22, 1'b1, 1'b0);
    cyc; iREG_en = 1'b0; neg; cyc; neg;
    checks++;
    if ({oLSB_en, oREG_nick_en, oIS_q1, oIS_v1} !== {1'b1, 1'b0, 4'd0, 32'd0}) begin
      errors++; $display("FAIL sw_x0 got lsb=%b ren=%b q1=%0d v1=%h want 1 0 0 0", oLSB_en, oREG_nick_en, oIS_q1, oIS_v1);
    end
    cyc; neg;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sw_x0_pending got=%0d want=0", sb.size()); end
  endtask

  task automatic test_cdb_held;
    logic [3:0] want;
    iROB_free_nick = 4'd8;
    offer(OP_ADD, 5'd8, 5'd9, 5'd10, 4'd2, 4'd0, 32'd0, 32'd5, 32'd0, 32'h500, 1'b0);
    expect_is(OP_ADD, 32'h500, 32'd0, 1'b0, 5'd8, 4'd8, 4'd0, 32'h1234, 4'd0, 32'd5, 1'b0, 1'b1);
    cyc; iREG_en = 1'b0; iRS_full = 1'b1; iCDB_en = 1'b1; iCDB_nick = 4'd2; iCDB_dt = 32'h1234; neg;
    checks++;
    if (oROB_q1_nick !== 4'd2) begin errors++; $display("FAIL cdb_lookup got=%0d want=2", oROB_q1_nick); end
    cyc; iCDB_en = 1'b0; neg;
`ifdef DP_CDB_BYPASS_EN
    want = 4'd0;
`else
    want = 4'd2;
`endif
    checks++;
    if (oROB_q1_nick !== want) begin errors++; $display("FAIL cdb_after_bcast got=%0d want=%0d", oROB_q1_nick, want); end
    iROB_q1_rdy = 1'b1; iROB_q1_dt = 32'h1234;
    cyc; iROB_q1_rdy = 1'b0; neg;
    checks++;
    if (oROB_q1_nick !== 4'd0) begin errors++; $display("FAIL cdb_after_rob got=%0d want=0", oROB_q1_nick); end
    iRS_full = 1'b0;
    cyc; neg;
    checks++;
    if ({oRS_en, oIS_v1} !== {1'b1, 32'h1234}) begin
      errors++; $display("FAIL cdb_held_issue got rs=%b v1=%h want 1 1234", oRS_en, oIS_v1);
    end
    cyc; neg;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL cdb_held_pending got=%0d want=0", sb.size()); end
  endtask

  task automatic test_cdb_direct;
    logic [3:0] want;
`ifdef DP_CDB_BYPASS_EN
    want = 4'd0;
`else
    want = 4'd2;
`endif
    iROB_free_nick = 4'd9;
    offer(OP_ADD, 5'd11, 5'd12, 5'd0, 4'd2, 4'd0, 32'd0, 32'd0, 32'd0, 32'h600, 1'b0);
    expect_is(OP_ADD, 32'h600, 32'd0, 1'b0, 5'd11, 4'd9, want, 32'h1234, 4'd0, 32'd0, 1'b0, 1'b1);
    cyc; iREG_en = 1'b0; iCDB_en = 1'b1; iCDB_nick = 4'd2; iCDB_dt = 32'h1234; neg;
    cyc; iCDB_en = 1'b0; neg;
    checks++;
    if ({oRS_en, oIS_q1} !== {1'b1, want}) begin
      errors++; $display("FAIL cdb_direct got rs=%b q1=%0d want 1 %0d", oRS_en, oIS_q1, want);
    end
    cyc; neg;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL cdb_direct_pending got=%0d want=0", sb.size()); end
  endtask

  task automatic test_rdy;
    iROB_free_nick = 4'd10;
    offer(OP_ADD, 5'd12, 5'd1, 5'd2, 4'd0, 4'd0, 32'd7, 32'd8, 32'd0, 32'h680, 1'b0);
    expect_is(OP_ADD, 32'h680, 32'd0, 1'b0, 5'd12, 4'd10, 4'd0, 32'd7, 4'd0, 32'd8, 1'b0, 1'b1);
    cyc; iREG_en = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc; neg;
      checks++;
      if ({oRS_en, oROB_en} !== 2'b00) begin
        errors++; $display("FAIL rdy_frozen%0d got rs/rob=%b want=00", i, {oRS_en, oROB_en});
      end
    end
    rdy = 1'b1;
    cyc; neg;
    checks++;
    if (oRS_en !== 1'b1) begin errors++; $display("FAIL rdy_resume got=%b want=1", oRS_en); end
    cyc; neg;
    checks++;
    if (oRS_en !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL rdy_done got rs=%b pending=%0d want 0 0", oRS_en, sb.size());
    end
  endtask

  task automatic test_clr;
    iROB_free_nick = 4'd11;
    offer(OP_ADD, 5'd13, 5'd1, 5'd2, 4'd0, 4'd0, 32'd1, 32'd2, 32'd0, 32'h700, 1'b0);
    cyc; iREG_en = 1'b0; clr = 1'b1; neg;
    checks++;
    if (oIND_stall !== 1'b0) begin errors++; $display("FAIL clr_unblocked got stall=%b want=0", oIND_stall); end
    cyc; clr = 1'b0; neg;
    checks++;
    if ({oROB_en, oRS_en, oLSB_en, oREG_nick_en, oIS_nick, oIS_pc} !== '0) begin
      errors++; $display("FAIL clr_flush got rob/rs/lsb/ren=%b nick=%0d pc=%h want 0", {oROB_en, oRS_en, oLSB_en, oREG_nick_en}, oIS_nick, oIS_pc);
    end
    iROB_free_nick = 4'd12;
    offer(OP_BEQ, 5'd0, 5'd1, 5'd2, 4'd0, 4'd0, 32'd3, 32'd4, 32'd16, 32'h704, 1'b1);
    expect_is(OP_BEQ, 32'h704, 32'd16, 1'b1, 5'd0, 4'd12, 4'd0, 32'd3, 4'd0, 32'd4, 1'b0, 1'b0);
    cyc; iREG_en = 1'b0; neg;
    checks++;
    if (oRS_en !== 1'b0) begin errors++; $display("FAIL clr_dropped got rs=%b want=0", oRS_en); end
    cyc; neg;
    checks++;
    if ({oRS_en, oREG_nick_en} !== 2'b10) begin
      errors++; $display("FAIL clr_next_beq got rs/ren=%b want=10", {oRS_en, oREG_nick_en});
    end
    cyc; neg;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL clr_pending got=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_stall;
    test_sw_x0;
    test_cdb_held;
    test_cdb_direct;
    test_rdy;
    test_clr;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule
